pmp_csr_regs: RTL
=================

Name: pmp_csr_regs

Overview:
- Machine-mode CSR register file that writes and holds the physical memory protection state: the pmpcfg and pmpaddr arrays.
- Decodes CSR reads and writes at 0x3A0–0x3EF, applies WARL and lock rules, and drives the per-entry config and address arrays consumed by the PMP checker.
- Sits in the privileged CSR unit in the Memory stage and produces the flattened per-entry arrays every cycle.

Parameters:
- XLEN, 64, CSR width; 32 or 64.
- PA_BITS, 56, physical address width; stored pmpaddr width is PA_BITS-2.
- PMP_ENTRIES, 16, implemented entries; 0, 16 or 64.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- CSRWriteM  input  1  CSR write strobe, Memory stage.
- CSRAdrM  input  12  CSR address for read and write.
- CSRWriteValM  input  XLEN  value to write.
- CSRReadValM  output  XLEN  combinational read data for CSRAdrM.
- IllegalPMPAccessM  output  1  CSRAdrM is in the PMP range but is not a legal register for this XLEN.
- PMPCFG_ARRAY_REGW  output  8 x PMP_ENTRIES  per-entry config byte {L,00,A[1:0],X,W,R}.
- PMPADDR_ARRAY_REGW  output  (PA_BITS-2) x PMP_ENTRIES  per-entry address, bits [PA_BITS-1:2].
- PMPChangeM  output  1  one-cycle pulse after a write that modified any stored bit.

Behaviour:
- Reset (synchronous, clk edge with reset=1): all cfg bytes = 0x00, all pmpaddr = 0, PMPChangeM = 0. Reset overrides a same-cycle CSRWriteM.
- Address map:
  - pmpcfgN at 0x3A0+N, N = 0..15. RV32: each holds entries 4N..4N+3. RV64: only even N are legal, each holding entries 4N..4N+7.
  - pmpaddrK at 0x3B0+K, K = 0..63.
- Write latency: a write is sampled on the clk edge where CSRWriteM=1 and becomes visible on outputs and on reads in the next cycle. Reads are combinational from current state; same-cycle read-during-write returns the old value.
- Bytes or entries with index >= PMP_ENTRIES: writes ignored, reads return 0.
- Odd pmpcfg on RV64: IllegalPMPAccessM=1, write ignored, read returns 0. IllegalPMPAccessM is combinational and independent of CSRWriteM.
- Per-cfg-byte write rules, evaluated independently per byte:
  - If stored L=1 for entry i, the byte is unchanged.
  - Bits 6:5 are always stored as 0.
  - If the written R=0 and W=1 (reserved combination), the entire byte keeps its old value.
- pmpaddr i write rules:
  - Ignored if entry i has L=1.
  - Ignored if entry i+1 exists, has L=1, and has A=TOR (01).
  - Otherwise stores CSRWriteValM[PA_BITS-3:0]. On RV32 the value is zero-extended when PA_BITS-2 > 32.
- pmpaddr read: zero-extended or truncated to XLEN.
- pmpcfg read: concatenation of the stored bytes, entry 4N (RV32) or 4N (RV64) in bits 7:0.
- Lock is sticky: cleared only by reset.
- Within one pmpcfg write:
  - Setting L takes effect for subsequent writes only.
  - A byte already locked is not unlocked by writing L=0.
- PMPChangeM: registered. It is 1 in the cycle after a write whose post-rule result differs from the old stored value in any bit, and 0 otherwise, including for ignored writes and writes of identical data. Reset mid-pulse forces it to 0.
- PMP_ENTRIES=0: arrays are empty, all PMP-range reads return 0, and PMPChangeM stays 0.
- Non-PMP addresses: CSRReadValM=0, IllegalPMPAccessM=0, no state change.

Test Plan:
1. Reset, then read every pmpcfg and pmpaddr: all 0, PMPChangeM=0 throughout.
2. RV64, write pmpcfg0=0x0000_0000_0000_1F0F, then read:
   - Read returns 0x...1F0F masked to 0x0000_0000_0000_1F0F with bits 6:5 of each byte 0.
   - cfg[0]=0x0F, cfg[1]=0x1F.
   - PMPChangeM pulses one cycle.
3. Write cfg byte 0 = 0x02 (W=1, R=0):
   - Byte 0 keeps its prior value 0x0F.
   - Byte 1 updates normally.
4. Write pmpaddr0=0x8000_0000 (takes effect).
   - Then write cfg[0]=0x8F (L=1).
   - Then write pmpaddr0=0x1234 and pmpcfg0 byte 0=0x00.
   - Both ignored: readback is 0x8000_0000 and 0x8F, no PMPChangeM pulse.
5. TOR lock propagation:
   - Set cfg[1]=0x88 (L=1, TOR).
   - Write pmpaddr0=0x55: ignored.
   - Write pmpaddr1=0x55: ignored.
   - Write pmpaddr2=0x55: accepted.
6. RV64 edge cases:
   - Access pmpcfg1 (0x3A1): IllegalPMPAccessM=1, write ignored.
   - With PMP_ENTRIES=16, pmpaddr20 write of 0xFFFF reads back 0.
   - Assert reset in the same cycle as a write: state = 0.

Source files
------------

// File: rtl/pmp_csr_regs.sv
// Machine-mode PMP CSR file: decodes pmpcfg/pmpaddr accesses, applies WARL and lock
// rules, and presents the per-entry config and address arrays to the PMP checker.
module pmp_csr_regs #(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned PA_BITS     = 56,
    parameter int unsigned PMP_ENTRIES = 16
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic                                                   CSRWriteM,
    input  logic [11:0]                                            CSRAdrM,
    input  logic [XLEN-1:0]                                        CSRWriteValM,
    output logic [XLEN-1:0]                                        CSRReadValM,
    output logic                                                   IllegalPMPAccessM,
    output logic [((PMP_ENTRIES == 0) ? 1 : PMP_ENTRIES)-1:0][7:0] PMPCFG_ARRAY_REGW,
    output logic [((PMP_ENTRIES == 0) ? 1 : PMP_ENTRIES)-1:0][PA_BITS-3:0] PMPADDR_ARRAY_REGW,
    output logic                                                   PMPChangeM
);

    localparam int unsigned AW  = PA_BITS - 2;
    localparam int unsigned NE  = (PMP_ENTRIES == 0) ? 1 : PMP_ENTRIES;
    localparam int unsigned BPC = XLEN / 8;

    // pmpcfg register number that holds entry i
    function automatic int unsigned cfgRegOf(input int unsigned i);
        return (XLEN == 32) ? (i / 4) : ((i / 8) * 2);
    endfunction

    // byte lane of entry i within its pmpcfg register
    function automatic int unsigned laneOf(input int unsigned i);
        return i % BPC;
    endfunction

    logic [NE-1:0][7:0]    cfgQ, cfgD;
    logic [NE-1:0][AW-1:0] addrQ, addrD;
    logic                  changeQ, changeD;
    logic [NE-1:0]         torLock;
    logic                  illegal, cfgSel, addrSel;
    logic [3:0]            cfgNum;
    logic [5:0]            addrNum;
    logic [XLEN-1:0]       readVal;
    logic [7:0]            wrByte;

    // address decode
    always_comb begin
        illegal = (XLEN == 64) && (CSRAdrM[11:4] == 8'h3A) && CSRAdrM[0];
        cfgSel  = (CSRAdrM[11:4] == 8'h3A) && !illegal;
        addrSel = (CSRAdrM >= 12'h3B0) && (CSRAdrM <= 12'h3EF);
        cfgNum  = CSRAdrM[3:0];
        addrNum = 6'(CSRAdrM - 12'h3B0);
    end

    // entry i is frozen when the next entry is a locked TOR region
    always_comb begin
        torLock = '0;
        for (int unsigned i = 0; i + 1 < NE; i++) begin
            torLock[i] = cfgQ[i+1][7] && (cfgQ[i+1][4:3] == 2'b01);
        end
    end

    // combinational read of current state
    always_comb begin
        readVal = '0;
        for (int unsigned i = 0; i < NE; i++) begin
            if (i < PMP_ENTRIES) begin
                if (cfgSel && (32'(cfgNum) == cfgRegOf(i))) begin
                    readVal[laneOf(i)*8 +: 8] = cfgQ[i];
                end
                if (addrSel && (32'(addrNum) == i)) begin
                    readVal = XLEN'(addrQ[i]);
                end
            end
        end
    end

    // next state with WARL and lock rules, judged against the old lock bits
    always_comb begin
        cfgD   = cfgQ;
        addrD  = addrQ;
        wrByte = '0;
        for (int unsigned i = 0; i < NE; i++) begin
            if ((i < PMP_ENTRIES) && CSRWriteM) begin
                wrByte = CSRWriteValM[laneOf(i)*8 +: 8];
                if (cfgSel && (32'(cfgNum) == cfgRegOf(i)) && !cfgQ[i][7]
                    && !(wrByte[1] && !wrByte[0])) begin
                    cfgD[i] = wrByte & 8'h9F;
                end
                if (addrSel && (32'(addrNum) == i) && !cfgQ[i][7] && !torLock[i]) begin
                    addrD[i] = AW'(CSRWriteValM);
                end
            end
        end
        changeD = (cfgD != cfgQ) || (addrD != addrQ);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfgQ    <= '0;
            addrQ   <= '0;
            changeQ <= 1'b0;
        end else begin
            cfgQ    <= cfgD;
            addrQ   <= addrD;
            changeQ <= changeD;
        end
    end

    assign CSRReadValM        = readVal;
    assign IllegalPMPAccessM  = illegal;
    assign PMPCFG_ARRAY_REGW  = cfgQ;
    assign PMPADDR_ARRAY_REGW = addrQ;
    assign PMPChangeM         = changeQ;

endmodule
